// File: rtl/rv_decode_pkg.sv
// Shared types for the RV32I decode stage: immediate formats, opcodes, the
// registered entry layout and the skid occupancy states.
package rv_decode_pkg;

  // pc/imm are stored at the widest legal XLEN; the stage truncates on output.
  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [2:0]          f3;
    logic [4:0]          r1;
    logic [4:0]          r2;
    logic [6:0]          f7;
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_t            fmt;
    logic                illegal;
  } decoded_t;

  function automatic logic is_known_op(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: is_known_op = 1'b1;
      default:                                     is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: instruction word -> format and
// sign-extended immediate of width XLEN.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    fmt   = FMT_R;
    imm32 = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_R;
        imm32 = '0;
      end
    endcase
  end

  // Every format's top bit is instr[31], so widening the 32-bit value signed is exact.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer and flush.
// Optional macro RV_DECODE_ILLEGAL_EN adds the out_illegal flag.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_f3,
  output logic [4:0]      out_r1,
  output logic [4:0]      out_r2,
  output logic [6:0]      out_f7,
  output logic [XLEN-1:0] out_imm,
`ifdef RV_DECODE_ILLEGAL_EN
  output logic            out_illegal,
`endif
  output logic [2:0]      out_fmt
);

  // Handshake: a beat moves on a port in any cycle where valid && ready are
  // both high at the rising edge; in_ready and out_valid are pure registers.
  skid_state_t state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  decoded_t    main_q;
  decoded_t    skid_q;
  decoded_t    dec;
  imm_fmt_t    dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic        in_xfer;
  logic        out_xfer;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  always_comb begin
    dec        = '0;
    dec.pc     = XLEN_MAX'(in_pc);
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.f3     = in_instr[14:12];
    dec.r1     = in_instr[19:15];
    dec.r2     = in_instr[24:20];
    dec.f7     = in_instr[31:25];
    dec.imm    = XLEN_MAX'($signed(dec_imm));
    dec.fmt    = dec_fmt;
`ifdef RV_DECODE_ILLEGAL_EN
    dec.illegal = !is_known_op(in_instr[6:0]) || (in_instr[1:0] != 2'b11) ||
                  ((in_instr[6:0] == OP_R) && (in_instr[31:25] != 7'b0000000) &&
                   (in_instr[31:25] != 7'b0100000));
`else
    dec.illegal = 1'b0;
`endif
  end

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q      <= dec;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              skid_q     <= dec;
              in_ready_q <= 1'b0;
              state_q    <= ST_FULL;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= ST_EMPTY;
            end
            2'b11: main_q <= dec;
            default: ;
          endcase
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (out_xfer) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = main_q.pc[XLEN-1:0];
  assign out_opcode = main_q.opcode;
  assign out_rd     = main_q.rd;
  assign out_f3     = main_q.f3;
  assign out_r1     = main_q.r1;
  assign out_r2     = main_q.r2;
  assign out_f7     = main_q.f7;
  assign out_imm    = main_q.imm[XLEN-1:0];
  assign out_fmt    = main_q.fmt;
`ifdef RV_DECODE_ILLEGAL_EN
  assign out_illegal = main_q.illegal;
`endif

  // Upper pc/imm bits (XLEN=32) and the illegal bit (feature off) are not driven out.
  logic unused_main;
  assign unused_main = ^main_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: spec-level queue model checked
// every cycle, plus directed vectors with hand-computed literals.
module tb_rv_decode_stage;

  localparam int XLEN = 32;
  localparam int W    = 96;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_f3;
  logic [4:0]      out_r1;
  logic [4:0]      out_r2;
  logic [6:0]      out_f7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
`ifdef RV_DECODE_ILLEGAL_EN
  logic            out_illegal;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Each entry is {pc (64), instr (32)} in arrival order.
  logic [W-1:0] exp_q[$];

  rv_decode_stage #(.XLEN(XLEN), .ILEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_f3     (out_f3),
    .out_r1     (out_r1),
    .out_r2     (out_r2),
    .out_f7     (out_f7),
    .out_imm    (out_imm),
`ifdef RV_DECODE_ILLEGAL_EN
    .out_illegal(out_illegal),
`endif
    .out_fmt    (out_fmt)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    else n_pass++;
  endtask

  // ---- Behavioural model ----
  function automatic logic [2:0] model_fmt(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: model_fmt = 3'd1;
      7'h23:                      model_fmt = 3'd2;
      7'h63:                      model_fmt = 3'd3;
      7'h37, 7'h17:               model_fmt = 3'd4;
      7'h6f:                      model_fmt = 3'd5;
      default:                    model_fmt = 3'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_imm(input logic [31:0] w);
    longint v;
    longint s;
    s = w[31] ? 1 : 0;
    case (model_fmt(w))
      3'd1: v = longint'(w[31:20]) - s * 4096;
      3'd2: v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - s * 4096;
      3'd3: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2 - s * 4096;
      3'd4: v = longint'(w[31:12]) * 4096 - s * (longint'(1) << 32);
      3'd5: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
                - s * (longint'(1) << 20);
      default: v = 0;
    endcase
    model_imm = v;
  endfunction

  function automatic logic model_illegal(input logic [31:0] w);
    logic known;
    known = (model_fmt(w) != 3'd0) || (w[6:0] == 7'h33);
    model_illegal = !known || (w[1:0] != 2'b11) ||
                    ((w[6:0] == 7'h33) && (w[31:25] != 7'h00) && (w[31:25] != 7'h20));
  endfunction

  // Occupancy model: up to two entries; input accepted only with a free slot.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      logic take;
      take = in_valid && (exp_q.size() < 2);
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (take) exp_q.push_back({64'(in_pc), in_instr});
    end
  end

  // Scoreboard compare, on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_data", {out_pc, out_opcode, out_rd, out_f3, out_r1, out_r2, out_f7}, 0);
      check("rst_imm_fmt", {out_imm, out_fmt}, 0);
    end else begin
      check("out_valid", out_valid, exp_q.size() > 0);
      check("in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() > 0 && out_valid) begin
        logic [31:0] w;
        logic [63:0] p;
        logic [63:0] im;
        w  = exp_q[0][31:0];
        p  = exp_q[0][95:32];
        im = model_imm(w);
        check("pc", out_pc, p[XLEN-1:0]);
        check("opcode", out_opcode, w[6:0]);
        check("rd", out_rd, w[11:7]);
        check("f3", out_f3, w[14:12]);
        check("r1", out_r1, w[19:15]);
        check("r2", out_r2, w[24:20]);
        check("f7", out_f7, w[31:25]);
        check("imm", out_imm, im[XLEN-1:0]);
        check("fmt", out_fmt, model_fmt(w));
`ifdef RV_DECODE_ILLEGAL_EN
        check("illegal", out_illegal, model_illegal(w));
`endif
      end
    end
  end

  // ---- Driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send(input logic [31:0] w, input logic [63:0] pc);
    logic rdy;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc[XLEN-1:0];
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // ---- Directed stimulus ----
  initial begin
    logic [31:0] vec[8];
    int c0;
    vec = '{32'h003100B3, 32'h01410093, 32'hFFF00093, 32'hFE000EE3,
            32'hFE112E23, 32'h12345037, 32'h008000EF, 32'h0000007F};

    repeat (2) @(posedge clk);
    #1;
    check("lit_rst_fmt", out_fmt, 3'd0);
    check("lit_rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    send(32'h003100B3, 64'h100);
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_add_valid", out_valid, 1);
    check("lit_add_opcode", out_opcode, 7'h33);
    check("lit_add_rd", out_rd, 5'd1);
    check("lit_add_f3", out_f3, 3'd0);
    check("lit_add_r1", out_r1, 5'd2);
    check("lit_add_r2", out_r2, 5'd3);
    check("lit_add_f7", out_f7, 7'd0);
    check("lit_add_fmt", out_fmt, 3'd0);
    check("lit_add_imm", out_imm, 0);
    check("lit_add_pc", out_pc, 32'h100);
    tick();

    send(32'h01410093, 64'h104);
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_addi_opcode", out_opcode, 7'h13);
    check("lit_addi_rd", out_rd, 5'd1);
    check("lit_addi_r1", out_r1, 5'd2);
    check("lit_addi_fmt", out_fmt, 3'd1);
    check("lit_addi_imm", out_imm, 32'd20);
    tick();

    send(32'hFFF00093, 64'h108);
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_neg_imm", out_imm, 32'hFFFFFFFF);
    tick();

    send(32'hFE000EE3, 64'h10C);
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_br_fmt", out_fmt, 3'd3);
    check("lit_br_imm", out_imm, 32'hFFFFFFFC);
    tick();

    // Remaining formats (S, U, J, unknown) go through the model only.
    for (int i = 4; i < 8; i++) send(vec[i], 64'h200 + 64'(i) * 4);
    idle(3);

    // Backpressure and ordering
    out_ready = 1'b0;
    send(32'h00A00513, 64'h300);
    send(32'h00B00593, 64'h304);
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_bp_in_ready", in_ready, 0);
    check("lit_bp_head", out_pc, 32'h300);
    tick();
    in_valid = 1'b1;
    in_instr = 32'h00C00613;
    in_pc    = 32'h308;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("lit_bp_head_still_a", out_pc, 32'h300);
    tick();
    @(negedge clk);
    check("lit_bp_second", out_pc, 32'h304);
    tick();
    @(negedge clk);
    check("lit_bp_drained", out_valid, 0);
    tick();

    // Streaming at one entry per cycle
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(vec[i], 64'h400 + 64'(i) * 4);
    check("lit_stream_cycles", 64'(cyc - c0), 8);
    idle(3);

    // Flush while full, with a competing input
    out_ready = 1'b0;
    send(32'h00100093, 64'h500);
    send(32'h00200113, 64'h504);
    in_valid = 1'b1;
    in_instr = 32'h00300193;
    in_pc    = 32'h508;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_flush_valid", out_valid, 0);
    check("lit_flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'hFFF00093, 64'h600);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("lit_arst_valid", out_valid, 0);
    check("lit_arst_in_ready", in_ready, 1);
    check("lit_arst_pc", out_pc, 0);
    check("lit_arst_imm", out_imm, 0);
    check("lit_arst_opcode", out_opcode, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);

`ifdef RV_DECODE_ILLEGAL_EN
    send(32'h00000000, 64'h700);
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_illegal_zero", out_illegal, 1);
    tick();
    idle(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
